shift_rx: RTL and testbench
===========================

# shift_rx

Serial-to-parallel receiver: the far end of a link driven by the 4-bit universal shift register used as a parallel-in/serial-out transmitter. It accepts one bit per strobe, MSB-first (matching shift-left) or LSB-first (matching shift-right), and assembles WIDTH-bit words framed by a start marker. Completed words are presented on a one-entry valid/ready output register, with sticky overflow and framing-error flags.

## Interface
- WIDTH, 4, word width in bits; minimum 2.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- dir  in  1  0 = MSB-first (shift left), 1 = LSB-first (shift right); sampled only at frame start.
- s_valid  in  1  serial bit strobe.
- s_first  in  1  frame start marker, qualified by s_valid.
- s_data  in  1  serial bit.
- p_ready  in  1  consumer accepts p_data.
- clr_err  in  1  clears overflow and frm_err.
- p_data  out  WIDTH  assembled word.
- p_valid  out  1  p_data holds an unconsumed word.
- busy  out  1  frame in progress (state COLLECT).
- overflow  out  1  sticky: completed word dropped because output register was full.
- frm_err  out  1  sticky: s_first seen mid-frame.

## Operation
- States: IDLE, COLLECT.
- IDLE: s_valid without s_first ignored. s_valid & s_first: latch dir, shift bit in, cnt = 1, go COLLECT.
- COLLECT, s_valid & !s_first: shift bit in, cnt + 1.
- COLLECT, s_valid & s_first: partial word discarded, frm_err = 1, restart exactly as from IDLE with this bit as bit 0.
- Shift rule: latched dir 0: sh = {sh[WIDTH-2:0], s_data}; dir 1: sh = {s_data, sh[WIDTH-1:1]}.
- Completion: the bit that makes cnt == WIDTH completes the word; go IDLE; the next word requires s_first.
- On completion, word goes to output register if p_valid == 0, or if p_valid & p_ready in the same cycle (drain and load together; p_valid stays 1 with the new word).
- Otherwise the word is dropped, overflow = 1, and the output register is unchanged.
- Output: p_valid & p_ready with no load in that cycle clears p_valid; p_data holds its last value.
- clr_err clears both flags; a set event in the same cycle wins.
- cnt width: $clog2(WIDTH+1); never exceeds WIDTH.

## Timing
- Reset values: p_data = 0, p_valid = 0, busy = 0, overflow = 0, frm_err = 0, state IDLE, cnt = 0, sh = 0.
- rst mid-frame discards the partial word and the pending output; the next word requires s_first.
- Latency: the last bit is sampled on edge N; p_valid = 1 and p_data are valid after edge N.
- Minimum word time is WIDTH cycles; back-to-back frames (s_first on the cycle after completion) are accepted with no gap cycle.
- Gaps in s_valid are allowed anywhere; state and cnt hold.
- busy rises after the s_first edge and falls after the completion edge.
- A 1-bit frame is impossible (WIDTH ≥ 2); s_first on the completing bit position is treated as a restart, not a completion.

## Structure
- Package shift_rx_pkg: state enum (IDLE, COLLECT), constants DIR_MSB_FIRST = 1'b0 and DIR_LSB_FIRST = 1'b1.
- Sub-module shift_rx_hold: one-entry valid/ready holding register with load, drain and drop/overflow logic.
- The top level holds the FSM, counter and shifter.

## Test plan
All scenarios use WIDTH = 4.
- MSB-first: dir = 0, bits 1,0,1,1 with s_first on the first bit, p_ready = 1 -> p_data = 4'b1011, p_valid high for 1 cycle, busy low afterwards.
- LSB-first: dir = 1, bits 1,0,1,1 -> p_data = 4'b1101.
- Gaps and noise: random idle cycles between bits, plus 3 strobes without s_first while in IDLE -> stray bits ignored, p_data = 4'b1011; dir toggled mid-frame has no effect.
- Backpressure: p_ready = 0, two frames 1011 then 0110 -> p_data stays 4'b1011 and overflow = 1; then p_ready = 1 -> p_valid clears; clr_err -> overflow = 0; clr_err in the same cycle as a new drop leaves overflow = 1.
- Resync: bits 1,1 then s_first with bits 0,0,1,0 -> frm_err = 1, p_data = 4'b0010, single p_valid.
- Reset: rst asserted after 2 bits of a frame, with p_valid = 1 -> all outputs 0 next cycle; following bits without s_first ignored; a fresh frame 1001 -> p_data = 4'b1001.

Source files
------------

// File: rtl/shift_rx_pkg.sv
// rtl/shift_rx_pkg.sv - shared types and constants for the serial-to-parallel receiver
package shift_rx_pkg;

  // Frame assembly state: waiting for a start marker, or collecting bits
  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  // Bit order on the link, latched at frame start
  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_rx_hold.sv
// rtl/shift_rx_hold.sv - one-entry valid/ready output register with drop/overflow tracking
module shift_rx_hold #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             p_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             overflow
);

  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic             p_valid_q, p_valid_d;
  logic             overflow_q, overflow_d;
  logic             accept;
  logic             drop;

  // Load when empty or when the current word drains this cycle; otherwise drop and flag
  always_comb begin
    accept     = load_valid && (!p_valid_q || p_ready);
    drop       = load_valid && !accept;
    p_data_d   = p_data_q;
    p_valid_d  = p_valid_q;
    overflow_d = overflow_q;
    if (accept) begin
      p_data_d  = load_data;
      p_valid_d = 1'b1;
    end else if (p_valid_q && p_ready) begin
      p_valid_d = 1'b0;
    end
    // A drop in the same cycle as clr_err leaves the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
  end

  // Output register state; reset also discards any pending word
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data_q   <= '0;
      p_valid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      p_data_q   <= p_data_d;
      p_valid_q  <= p_valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign p_data   = p_data_q;
  assign p_valid  = p_valid_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/shift_rx.sv
// rtl/shift_rx.sv - framed serial-to-parallel receiver, MSB- or LSB-first
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dir,
  input  logic             s_valid,
  input  logic             s_first,
  input  logic             s_data,
  input  logic             p_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             busy,
  output logic             overflow,
  output logic             frm_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] sh_base;
  logic             dir_q, dir_d;
  logic             frm_err_q, frm_err_d;
  logic             do_shift;
  logic             frm_set;
  logic             word_valid;

  // Frame FSM, bit counter and shifter; s_first always restarts, even mid-frame
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    sh_d       = sh_q;
    sh_base    = sh_q;
    do_shift   = 1'b0;
    frm_set    = 1'b0;
    word_valid = 1'b0;
    if (s_valid) begin
      if (s_first) begin
        // Any partial word is abandoned; this bit becomes bit 0 of a new frame
        frm_set  = (state_q == COLLECT);
        dir_d    = dir;
        sh_base  = '0;
        do_shift = 1'b1;
        cnt_d    = CW'(1);
        state_d  = COLLECT;
      end else if (state_q == COLLECT) begin
        do_shift = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          word_valid = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
    end
    if (do_shift) begin
      if (dir_d == DIR_MSB_FIRST) begin
        sh_d = {sh_base[WIDTH-2:0], s_data};
      end else begin
        sh_d = {s_data, sh_base[WIDTH-1:1]};
      end
    end
    if (frm_set) begin
      frm_err_d = 1'b1;
    end else if (clr_err) begin
      frm_err_d = 1'b0;
    end else begin
      frm_err_d = frm_err_q;
    end
  end

  // Receiver state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      dir_q     <= DIR_MSB_FIRST;
      frm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      dir_q     <= dir_d;
      frm_err_q <= frm_err_d;
    end
  end

  shift_rx_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load_valid(word_valid),
    .load_data (sh_d),
    .p_ready   (p_ready),
    .clr_err   (clr_err),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .overflow  (overflow)
  );

  assign busy    = (state_q == COLLECT);
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_shift_rx.sv
// tb/tb_shift_rx.sv - scoreboard bench for shift_rx with WIDTH = 4
module tb_shift_rx;

  logic       clk;
  logic       rst;
  logic       dir;
  logic       s_valid;
  logic       s_first;
  logic       s_data;
  logic       p_ready;
  logic       clr_err;
  logic [3:0] p_data;
  logic       p_valid;
  logic       busy;
  logic       overflow;
  logic       frm_err;

  int         checks;
  int         errors;
  int         hs_count;
  logic [3:0] exp_q[$];

  shift_rx #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .dir     (dir),
    .s_valid (s_valid),
    .s_first (s_first),
    .s_data  (s_data),
    .p_ready (p_ready),
    .clr_err (clr_err),
    .p_data  (p_data),
    .p_valid (p_valid),
    .busy    (busy),
    .overflow(overflow),
    .frm_err (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every handshake pops and compares the oldest expected word
  always @(negedge clk) begin
    logic [3:0] exp_w;
    if (!rst && p_valid && p_ready) begin
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected_word: got p_data=%b, expected no word", p_data);
      end else begin
        exp_w = exp_q.pop_front();
        if (p_data !== exp_w) begin
          errors++;
          $display("FAIL mon_word: got p_data=%b, expected %b", p_data, exp_w);
        end
      end
    end
  end

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic first);
    s_valid = 1'b1;
    s_first = first;
    s_data  = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
    s_data  = 1'b0;
  endtask

  // seq[3] is sent first, with s_first; optional random gaps and dir toggling
  task automatic send_seq(input logic [3:0] seq, input int max_gap, input logic toggle);
    for (int i = 3; i >= 0; i--) begin
      send_bit(seq[i], i == 3);
      if (toggle) dir = ~dir;
      if (max_gap > 0 && i > 0) idle(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset_state();
    chk("reset_p_data", p_data, 4'b0000);
    chk("reset_p_valid", {3'b0, p_valid}, 4'b0);
    chk("reset_busy", {3'b0, busy}, 4'b0);
    chk("reset_overflow", {3'b0, overflow}, 4'b0);
    chk("reset_frm_err", {3'b0, frm_err}, 4'b0);
  endtask

  task automatic test_msb_first();
    int hs0;
    p_ready = 1'b1;
    dir = 1'b0;
    hs0 = hs_count;
    exp_q.push_back(4'b1011);
    send_bit(1'b1, 1'b1);
    chk("msb_busy_mid", {3'b0, busy}, 4'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("msb_p_valid", {3'b0, p_valid}, 4'b1);
    chk("msb_p_data", p_data, 4'b1011);
    chk("msb_busy_after", {3'b0, busy}, 4'b0);
    idle(1);
    chk("msb_p_valid_cleared", {3'b0, p_valid}, 4'b0);
    chk("msb_handshakes", 4'(hs_count - hs0), 4'd1);
  endtask

  task automatic test_lsb_first();
    p_ready = 1'b1;
    dir = 1'b1;
    exp_q.push_back(rev4(4'b1011));
    send_seq(4'b1011, 0, 1'b0);
    chk("lsb_p_data", p_data, 4'b1101);
    idle(1);
  endtask

  task automatic test_gaps_noise();
    p_ready = 1'b1;
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(i[0], 1'b0);
      idle(1);
    end
    chk("noise_busy", {3'b0, busy}, 4'b0);
    chk("noise_p_valid", {3'b0, p_valid}, 4'b0);
    exp_q.push_back(4'b1011);
    send_seq(4'b1011, 3, 1'b1);
    chk("gaps_p_data", p_data, 4'b1011);
    chk("gaps_p_valid", {3'b0, p_valid}, 4'b1);
    idle(1);
  endtask

  task automatic test_backpressure();
    p_ready = 1'b0;
    dir = 1'b0;
    exp_q.push_back(4'b1011);
    send_seq(4'b1011, 0, 1'b0);
    send_seq(4'b0110, 0, 1'b0);
    chk("bp_p_data_held", p_data, 4'b1011);
    chk("bp_overflow", {3'b0, overflow}, 4'b1);
    chk("bp_p_valid", {3'b0, p_valid}, 4'b1);
    p_ready = 1'b1;
    idle(1);
    chk("bp_drained", {3'b0, p_valid}, 4'b0);
    chk("bp_overflow_sticky", {3'b0, overflow}, 4'b1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("bp_overflow_cleared", {3'b0, overflow}, 4'b0);
    p_ready = 1'b0;
    exp_q.push_back(4'b0101);
    send_seq(4'b0101, 0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    clr_err = 1'b1;
    send_bit(1'b0, 1'b0);
    clr_err = 1'b0;
    chk("bp_set_wins_clr", {3'b0, overflow}, 4'b1);
    chk("bp_p_data_held2", p_data, 4'b0101);
    p_ready = 1'b1;
    idle(1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
  endtask

  task automatic test_resync();
    int hs0;
    p_ready = 1'b1;
    dir = 1'b0;
    hs0 = hs_count;
    chk("resync_frm_err_pre", {3'b0, frm_err}, 4'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    exp_q.push_back(4'b0010);
    send_seq(4'b0010, 0, 1'b0);
    chk("resync_frm_err", {3'b0, frm_err}, 4'b1);
    chk("resync_p_data", p_data, 4'b0010);
    idle(2);
    chk("resync_single_valid", 4'(hs_count - hs0), 4'd1);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("resync_frm_err_cleared", {3'b0, frm_err}, 4'b0);
  endtask

  task automatic test_reset_midframe();
    p_ready = 1'b0;
    dir = 1'b0;
    send_seq(4'b1011, 0, 1'b0);
    chk("rst_pre_p_valid", {3'b0, p_valid}, 4'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    chk("rst_pre_busy", {3'b0, busy}, 4'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_p_data", p_data, 4'b0000);
    chk("rst_p_valid", {3'b0, p_valid}, 4'b0);
    chk("rst_busy", {3'b0, busy}, 4'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("rst_orphans_busy", {3'b0, busy}, 4'b0);
    chk("rst_orphans_p_valid", {3'b0, p_valid}, 4'b0);
    p_ready = 1'b1;
    exp_q.push_back(4'b1001);
    send_seq(4'b1001, 0, 1'b0);
    chk("rst_fresh_p_data", p_data, 4'b1001);
    idle(1);
  endtask

  task automatic test_back_to_back();
    p_ready = 1'b1;
    dir = 1'b0;
    exp_q.push_back(4'b1100);
    exp_q.push_back(4'b0101);
    send_seq(4'b1100, 0, 1'b0);
    chk("b2b_first_p_data", p_data, 4'b1100);
    send_seq(4'b0101, 0, 1'b0);
    chk("b2b_second_p_data", p_data, 4'b0101);
    chk("b2b_no_overflow", {3'b0, overflow}, 4'b0);
    idle(2);
    chk("b2b_queue_empty", 4'(exp_q.size()), 4'd0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    hs_count = 0;
    rst      = 1'b1;
    dir      = 1'b0;
    s_valid  = 1'b0;
    s_first  = 1'b0;
    s_data   = 1'b0;
    p_ready  = 1'b0;
    clr_err  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset_state();
    test_msb_first();
    test_lsb_first();
    test_gaps_noise();
    test_backpressure();
    test_resync();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
